// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite ROM sharing path.
// One ROM instance holds 1920 palette-index pixels; all on-screen characters read it.
package sprite_pkg;
  localparam int ROM_DEPTH          = 1920;
  localparam int SPRITE_ADDR_W      = 19;
  localparam int SPRITE_DATA_W      = 5;
  localparam int NUM_SPRITE_CLIENTS = 4;

  typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;
  typedef logic [SPRITE_DATA_W-1:0] sprite_pix_t;
endpackage : sprite_pkg

// File: rtl/sprite_rom_arbiter_if.sv
// Bundle of client request/return signals plus the ROM address/data pair.
// The slave side is the arbiter; the master side is the draw clients together with the ROM.
interface sprite_rom_arbiter_if
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = NUM_SPRITE_CLIENTS,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = SPRITE_DATA_W
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             rd_valid;
  logic [DATA_W-1:0]              rd_data;
  logic                           rd_oob;
  logic [ADDR_W-1:0]              rom_addr;
  logic [DATA_W-1:0]              rom_data;

  modport slave (
    input  req, addr, rom_data,
    output gnt, rd_valid, rd_data, rd_oob, rom_addr
  );

  modport master (
    output req, addr, rom_data,
    input  gnt, rd_valid, rd_data, rd_oob, rom_addr
  );
endinterface : sprite_rom_arbiter_if

// File: rtl/sprite_rom_arbiter_rr.sv
// Purely combinational round-robin pick: scans req from ptr upward, wrapping,
// and reports the first requester as a one-hot grant plus its index.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int slot;

  // First requester at or after ptr wins; later hits are ignored once valid_o is set.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    slot    = 0;
    for (int k = 0; k < N; k++) begin
      slot = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[slot]) begin
        valid_o     = 1'b1;
        gnt_o[slot] = 1'b1;
        idx_o       = IDX_W'(slot);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one sync-read sprite ROM among NUM_REQ draw clients.
// One grant per cycle, data returned exactly one cycle later with a one-hot owner tag.
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = sprite_pkg::NUM_SPRITE_CLIENTS,
  parameter int ADDR_W    = sprite_pkg::SPRITE_ADDR_W,
  parameter int DATA_W    = sprite_pkg::SPRITE_DATA_W,
  parameter int ROM_DEPTH = sprite_pkg::ROM_DEPTH
) (
  input logic                 Clk,
  input logic                 Reset_n,
  sprite_rom_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] arbGnt;
  logic [IDX_W-1:0]   arbIdx;
  logic               arbValid;
  logic               grantLive;
  logic [ADDR_W-1:0]  selAddr;
  logic               selOob;

  logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
  logic [NUM_REQ-1:0] rdValid_q, rdValid_d;
  logic               oob_q, oob_d;

  rr_arbiter #(.N(NUM_REQ)) uArb (
    .req_i   (bus.req),
    .ptr_i   (rrPtr_q),
    .gnt_o   (arbGnt),
    .idx_o   (arbIdx),
    .valid_o (arbValid)
  );

  // Grants are suppressed during reset so nothing enters the return pipe then.
  always_comb begin
    grantLive = arbValid & Reset_n;
    selAddr   = bus.addr[arbIdx];
    selOob    = (selAddr >= ADDR_W'(ROM_DEPTH));

    rrPtr_d = rrPtr_q;
    if (grantLive) begin
      rrPtr_d = (arbIdx == IDX_W'(NUM_REQ - 1)) ? '0 : arbIdx + 1'b1;
    end

    rdValid_d = grantLive ? arbGnt : '0;
    oob_d     = grantLive & selOob;
  end

  // Out-of-range reads never reach the ROM; their return slot is forced to zero instead.
  assign bus.gnt      = grantLive ? arbGnt : '0;
  assign bus.rom_addr = (grantLive && !selOob) ? selAddr : '0;
  assign bus.rd_valid = rdValid_q;
  assign bus.rd_oob   = oob_q;
  assign bus.rd_data  = ((|rdValid_q) && !oob_q) ? bus.rom_data : '0;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rrPtr_q   <= '0;
      rdValid_q <= '0;
      oob_q     <= 1'b0;
    end else begin
      rrPtr_q   <= rrPtr_d;
      rdValid_q <= rdValid_d;
      oob_q     <= oob_d;
    end
  end

endmodule : sprite_rom_arbiter

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios then random traffic, all checked
// against a cycle-level reference model of round-robin grant and 1-cycle ROM return.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  localparam int N = NUM_SPRITE_CLIENTS;

  logic Clk;
  logic Reset_n;
  int   nCompared;
  int   nMismatched;

  // Reference model state: next grant start point and the return expected next cycle.
  int           modelPtr;
  logic [N-1:0] expValid;
  logic [4:0]   expData;
  logic         expOob;

  sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(SPRITE_ADDR_W), .DATA_W(SPRITE_DATA_W)) bus ();

  sprite_rom_arbiter dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Sprite ROM stand-in: synchronous read, word k holds k[4:0].
  always_ff @(posedge Clk) begin
    bus.rom_data <= bus.rom_addr[4:0];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, checks every output against the model, then advances the model.
  task automatic applyStimulus(input logic rstn, input logic [N-1:0] reqV,
                               input logic [N-1:0][SPRITE_ADDR_W-1:0] addrV);
    logic [N-1:0]             wantGnt;
    logic [SPRITE_ADDR_W-1:0] wantRomAddr;
    int                       winner;
    @(negedge Clk);
    Reset_n  = rstn;
    bus.req  = reqV;
    bus.addr = addrV;
    #1;
    wantGnt     = '0;
    wantRomAddr = '0;
    winner      = -1;
    if (rstn) begin
      for (int k = 0; k < N; k++) begin
        if (winner < 0 && reqV[(modelPtr + k) % N]) winner = (modelPtr + k) % N;
      end
    end
    if (winner >= 0) begin
      wantGnt[winner] = 1'b1;
      if (addrV[winner] < ROM_DEPTH) wantRomAddr = addrV[winner];
    end
    checkOutput("gnt",      32'(bus.gnt),      32'(wantGnt));
    checkOutput("rom_addr", 32'(bus.rom_addr), 32'(wantRomAddr));
    checkOutput("rd_valid", 32'(bus.rd_valid), 32'(expValid));
    checkOutput("rd_data",  32'(bus.rd_data),  32'(expData));
    checkOutput("rd_oob",   32'(bus.rd_oob),   32'(expOob));
    expValid = wantGnt;
    expData  = '0;
    expOob   = 1'b0;
    if (!rstn) begin
      modelPtr = 0;
    end else if (winner >= 0) begin
      modelPtr = (winner + 1) % N;
      if (addrV[winner] >= ROM_DEPTH) expOob = 1'b1;
      else expData = addrV[winner][4:0];
    end
  endtask

  logic [N-1:0][SPRITE_ADDR_W-1:0] a;
  logic [N-1:0]                    r;

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    modelPtr    = 0;
    expValid    = '0;
    expData     = '0;
    expOob      = 1'b0;
    Reset_n     = 1'b0;
    bus.req     = '0;
    bus.addr    = '0;
    repeat (2) @(posedge Clk);

    // Single client read with reset state checked first.
    a = '0;
    applyStimulus(1'b0, 4'b0000, a);
    a[0] = 19'd5;
    applyStimulus(1'b1, 4'b0001, a);
    checkOutput("t1_gnt", 32'(bus.gnt), 32'h1);
    applyStimulus(1'b1, 4'b0000, a);
    checkOutput("t1_valid", 32'(bus.rd_valid), 32'h1);
    checkOutput("t1_data",  32'(bus.rd_data),  32'd5);

    // Full load from pointer 0: strict rotation, no bubbles.
    applyStimulus(1'b0, 4'b0000, a);
    a[0] = 19'd100; a[1] = 19'd201; a[2] = 19'd302; a[3] = 19'd1919;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'b1111, a);
      checkOutput("t2_gnt", 32'(bus.gnt), 32'(1 << (i % 4)));
    end

    // Pointer at 2 skips client 1 in favour of client 3.
    applyStimulus(1'b1, 4'b0010, a);
    applyStimulus(1'b1, 4'b1010, a);
    checkOutput("t3_gnt_a", 32'(bus.gnt), 32'h8);
    applyStimulus(1'b1, 4'b0010, a);
    checkOutput("t3_gnt_b", 32'(bus.gnt), 32'h2);

    // Range boundary: 1920 is rejected, 1919 is the last valid word.
    a[2] = 19'd1920;
    applyStimulus(1'b1, 4'b0100, a);
    checkOutput("t4_romaddr", 32'(bus.rom_addr), 32'd0);
    a[2] = 19'd1919;
    applyStimulus(1'b1, 4'b0100, a);
    checkOutput("t4_oob", 32'(bus.rd_oob), 32'd1);
    applyStimulus(1'b1, 4'b0000, a);
    checkOutput("t4_data", 32'(bus.rd_data), 32'd31);
    a[2] = 19'h7FFFF;
    applyStimulus(1'b1, 4'b0100, a);
    applyStimulus(1'b1, 4'b0000, a);

    // Reset pulse while streaming.
    applyStimulus(1'b1, 4'b1111, a);
    applyStimulus(1'b1, 4'b1111, a);
    applyStimulus(1'b0, 4'b1111, a);
    checkOutput("t5_gnt_rst", 32'(bus.gnt), 32'd0);
    applyStimulus(1'b1, 4'b1111, a);
    checkOutput("t5_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("t5_gnt0",  32'(bus.gnt),      32'h1);

    // Same client back-to-back with changing address.
    for (int i = 0; i < 3; i++) begin
      a[0] = SPRITE_ADDR_W'(10 + i);
      applyStimulus(1'b1, 4'b0001, a);
    end
    applyStimulus(1'b1, 4'b0000, a);
    checkOutput("t6_data", 32'(bus.rd_data), 32'd12);

    // Random traffic with occasional resets and out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0) a[c] = SPRITE_ADDR_W'($urandom);
        else a[c] = SPRITE_ADDR_W'($urandom_range(1900, 1940));
        if ($urandom_range(0, 3) == 0) a[c] = SPRITE_ADDR_W'($urandom_range(0, 1919));
      end
      applyStimulus(($urandom_range(0, 39) != 0), r, a);
    end
    applyStimulus(1'b1, 4'b0000, a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_sprite_rom_arbiter
